// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter (LSB first, idle-high line).
//
// Takes one byte from a valid/ready producer and serializes it as
// start(0), d0..d7, [parity], stop(1). Each bit lasts BIT_TIME clocks.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : a parity bit (XOR of data, XOR PARITY_ODD) is inserted
//               between d7 and stop; the frame is 11*BIT_TIME clocks.
//   undefined : plain 8N1; the frame is 10*BIT_TIME clocks.
//
// Parameters:
//   BIT_TIME    clocks per serial bit, 2..255 (8-bit counter)
//   PARITY_ODD  0 = even parity, 1 = odd parity (parity build only)
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset
//   tx_valid  producer has a byte on tx_data
//   tx_data   byte to send, sampled only on accept
//   tx_ready  high in IDLE: a byte can be accepted this cycle
//   tx        registered serial line, idle high
//   tx_busy   frame in progress (START/DATA/PARITY/STOP)
//   tx_done   one-cycle pulse in the first IDLE cycle after STOP
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int BIT_TIME   = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam logic [7:0] LAST_CNT = 8'(BIT_TIME - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_clk_cnt, w_clk_cnt_nxt;
  logic [2:0] r_bit_idx, w_bit_idx_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_tx, w_tx_nxt;
  logic       r_done, w_done_nxt;
  logic       w_last;

`ifndef UART_TX_PARITY_EN
  // Parity sense has no meaning in the 8N1 build.
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
`endif

  assign w_last = (r_clk_cnt == LAST_CNT);

  // Next-state logic.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_done_nxt    = 1'b0;
    // The counter only runs inside a frame and wraps at the bit boundary.
    if (r_state == S_IDLE) w_clk_cnt_nxt = 8'd0;
    else if (w_last)       w_clk_cnt_nxt = 8'd0;
    else                   w_clk_cnt_nxt = r_clk_cnt + 8'd1;

    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_state_nxt = S_START;
          w_shift_nxt = tx_data;
        end
      end
      S_START: begin
        if (w_last) begin
          w_state_nxt   = S_DATA;
          w_bit_idx_nxt = 3'd0;
        end
      end
      S_DATA: begin
        if (w_last) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_last) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line value for the state being entered; registering it keeps tx glitch
  // free and puts the start bit on the line the cycle after accept.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_IDLE:   w_tx_nxt = 1'b1;
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[w_bit_idx_nxt];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = (^r_shift) ^ PARITY_ODD;
`endif
      S_STOP:   w_tx_nxt = 1'b1;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= 8'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign tx       = r_tx;
  assign tx_done  = r_done;
  assign tx_ready = (r_state == S_IDLE);
  assign tx_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// Two instances: BIT_TIME=16 / PARITY_ODD=0 and BIT_TIME=2 / PARITY_ODD=1.
// A frame-level model expands each accepted byte into the expected per-cycle
// line/busy/done sequence; a table of hand-derived samples pins key cycles.
// ---------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v16 = 1'b0, v2 = 1'b0;
  logic [7:0] d16 = 8'h00, d2 = 8'h00;
  logic       rdy16, tx16, busy16, done16;
  logic       rdy2, tx2, busy2, done2;

  always #5 clk = ~clk;

  uart_tx #(.BIT_TIME(16), .PARITY_ODD(1'b0)) u_dut16 (
    .clk(clk), .reset(reset), .tx_valid(v16), .tx_data(d16),
    .tx_ready(rdy16), .tx(tx16), .tx_busy(busy16), .tx_done(done16));

  uart_tx #(.BIT_TIME(2), .PARITY_ODD(1'b1)) u_dut2 (
    .clk(clk), .reset(reset), .tx_valid(v2), .tx_data(d2),
    .tx_ready(rdy2), .tx(tx2), .tx_busy(busy2), .tx_done(done2));

  typedef struct packed {logic tx; logic busy; logic done;} samp_t;
  typedef struct {
    bit         sel;
    logic [7:0] data;
    int         off;
    logic       exp_tx;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     n_done   = 0;
  bit     sel      = 1'b0;
  samp_t  q[$];
  vec_t   vecs[$];
  logic   obs_tx, obs_busy, obs_done, obs_ready;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)",
               name, act, exp, sel, $time);
    end
  endtask

  // Expand an accepted byte into the cycles that follow the accept edge.
  task automatic push_frame(input logic [7:0] d);
    int   bt;
    logic podd;
    logic bits[$];
    bt   = sel ? 2 : 16;
    podd = sel ? 1'b1 : 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back((^d) ^ podd);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (bt) q.push_back('{tx: bits[i], busy: 1'b1, done: 1'b0});
    q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
  endtask

  // One clock: sample on the falling edge, compare to the model, then drive
  // the inputs that the next rising edge will see.
  task automatic tick(input logic v, input logic [7:0] d);
    samp_t cur;
    @(negedge clk);
    if (q.size() > 0) cur = q.pop_front();
    else              cur = '{tx: 1'b1, busy: 1'b0, done: 1'b0};
    obs_tx    = sel ? tx2   : tx16;
    obs_busy  = sel ? busy2 : busy16;
    obs_done  = sel ? done2 : done16;
    obs_ready = sel ? rdy2  : rdy16;
    check("model_tx",    32'(obs_tx),    32'(cur.tx));
    check("model_busy",  32'(obs_busy),  32'(cur.busy));
    check("model_done",  32'(obs_done),  32'(cur.done));
    check("model_ready", 32'(obs_ready), 32'(!cur.busy));
    if (obs_done) n_done++;
    v16 = sel ? 1'b0 : v;  d16 = sel ? 8'h00 : d;
    v2  = sel ? v : 1'b0;  d2  = sel ? d : 8'h00;
    if (v && !cur.busy) push_frame(d);
  endtask

  task automatic go_idle();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      tick(1'b0, 8'($urandom));
      n++;
    end
    check("idle_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl;
    // Hand-derived samples: offsets count clocks after the accept edge.
    vecs.push_back('{1'b0, 8'hA5, 1,   1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, 16,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, 17,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, 32,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, 33,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, 49,  1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, 65,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, 129, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, (FB-1)*16+1, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, FB*16,       1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, FB*16+1,     1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'hF0, 1,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'hF0, 2,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'hF0, 3,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'hF0, 10, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'hF0, 11, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'hF0, 18, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'hF0, FB*2,   1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'hF0, FB*2+1, 1'b1, 1'b0, 1'b1});
`ifdef UART_TX_PARITY_EN
    vecs.push_back('{1'b0, 8'hA5, 145, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'hA5, 160, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h07, 145, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h07, 160, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h07, 176, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 8'h07, 177, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 8'h07, 19,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 8'h07, 20,  1'b0, 1'b1, 1'b0});
`endif

    // Reset values on both instances.
    @(negedge clk);
    check("rst_tx16",   32'(tx16),   32'd1);
    check("rst_rdy16",  32'(rdy16),  32'd1);
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_done16", 32'(done16), 32'd0);
    check("rst_tx2",    32'(tx2),    32'd1);
    check("rst_rdy2",   32'(rdy2),   32'd1);
    check("rst_busy2",  32'(busy2),  32'd0);
    check("rst_done2",  32'(done2),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven samples, one fresh frame per record.
    foreach (vecs[i]) begin
      go_idle();
      sel = vecs[i].sel;
      tick(1'b1, vecs[i].data);
      repeat (vecs[i].off) tick(1'b0, 8'($urandom));
      check($sformatf("vec%0d_tx", i),   32'(obs_tx),   32'(vecs[i].exp_tx));
      check($sformatf("vec%0d_busy", i), 32'(obs_busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(obs_done), 32'(vecs[i].exp_done));
    end
    go_idle();

    // Back-to-back: valid held high, 0x00 then 0xFF.
    sel = 1'b0;
    fl  = FB * 16;
    tick(1'b1, 8'h00);
    for (int k = 1; k <= fl + 1; k++) tick(1'b1, 8'hFF);
    check("b2b_done_cycle",  32'(obs_done),  32'd1);
    check("b2b_ready_cycle", 32'(obs_ready), 32'd1);
    check("b2b_stop_high",   32'(obs_tx),    32'd1);
    tick(1'b0, 8'h00);
    check("b2b_second_start", 32'(obs_tx), 32'd0);
    repeat (16) tick(1'b0, 8'h00);
    check("b2b_ff_bit0", 32'(obs_tx), 32'd1);
    go_idle();

    // Busy rejection: 0x3C / changing data offered while 0x81 is in flight.
    n_done = 0;
    tick(1'b1, 8'h81);
    for (int k = 1; k < fl - 4; k++) tick(1'b1, (k % 2) ? 8'h3C : 8'($urandom));
    check("rej_ready_busy", 32'(obs_ready), 32'd0);
    repeat (30) tick(1'b0, 8'h3C);
    go_idle();
    check("rej_one_done", 32'(n_done), 32'd1);

    // Reset during data bit 3 of 0x55, then a clean 0x12.
    n_done = 0;
    tick(1'b1, 8'h55);
    repeat (70) tick(1'b0, 8'h00);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_tx",    32'(tx16),   32'd1);
    check("rst_mid_ready", 32'(rdy16),  32'd1);
    check("rst_mid_busy",  32'(busy16), 32'd0);
    check("rst_mid_done",  32'(done16), 32'd0);
    q.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) tick(1'b0, 8'h00);
    check("rst_no_done", 32'(n_done), 32'd0);
    tick(1'b1, 8'h12);
    go_idle();
    check("rst_then_12_done", 32'(n_done), 32'd1);

    // Randomized traffic on both instances against the model.
    for (int s = 0; s < 2; s++) begin
      go_idle();
      sel = s[0];
      for (int k = 0; k < 800; k++)
        tick(($urandom_range(0, 7) == 0), 8'($urandom));
      go_idle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
